// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry in-order FIFO of {inst, pc} between fetch and decode.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_buffer #(
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc,
  input  logic            id_ready,
`ifdef IF_ID_PERF_EN
  output logic [15:0]     perf_issued,
  output logic [15:0]     perf_stall,
`endif
  input  logic            flush
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]      count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [31:0]     inst_q [2];
  logic [31:0]     inst_d [2];
  logic [PC_W-1:0] pc_q [2];
  logic [PC_W-1:0] pc_d [2];
  logic            push, pop;

  assign if_ready = (count_q != FULL) && !rst;
  assign id_valid = (count_q != EMPTY);
  assign id_inst  = id_valid ? inst_q[rd_ptr_q] : '0;
  assign id_pc    = id_valid ? pc_q[rd_ptr_q]   : '0;
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    // Flush only rewinds bookkeeping; stale entries are unreachable once count is 0.
    if (flush) begin
      count_d  = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = if_inst;
        pc_d[wr_ptr_q]   = if_pc;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      inst_q   <= '{default: '0};
      pc_q     <= '{default: '0};
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (pop && (issued_q != '1)) begin
      issued_d = issued_q + 16'd1;
    end
    if (id_valid && !id_ready && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_if_id_buffer;

  localparam int PC_W = 6;

  logic            clk = 1'b0;
  logic            rst, flush, if_valid, id_ready;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;
  logic            if_ready, id_valid;
  logic [31:0]     id_inst;
  logic [PC_W-1:0] id_pc;
`ifdef IF_ID_PERF_EN
  logic [15:0]     perf_issued, perf_stall;
`endif

  if_id_buffer #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
`ifdef IF_ID_PERF_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .flush       (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t model_q[$];
  int     total = 0;
  int     bad = 0;
  bit     checking = 0;
  int     exp_issued = 0;
  int     exp_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic fl, input logic v,
                       input logic [31:0] ins, input logic [PC_W-1:0] p,
                       input logic rdy, input string tag);
    entry_t e;
    bit     can_pop, can_push;
    rst = r; flush = fl; if_valid = v; if_inst = ins; if_pc = p; id_ready = rdy;
    #2;
    if (checking) begin
      chk({tag, ".if_ready"}, 64'(if_ready), 64'((model_q.size() < 2) && !r));
      chk({tag, ".id_valid"}, 64'(id_valid), 64'(model_q.size() != 0));
      chk({tag, ".id_inst"}, 64'(id_inst), (model_q.size() != 0) ? 64'(model_q[0].inst) : 64'd0);
      chk({tag, ".id_pc"}, 64'(id_pc), (model_q.size() != 0) ? 64'(model_q[0].pc) : 64'd0);
`ifdef IF_ID_PERF_EN
      chk({tag, ".perf_issued"}, 64'(perf_issued), 64'(exp_issued));
      chk({tag, ".perf_stall"}, 64'(perf_stall), 64'(exp_stall));
`endif
    end
    @(posedge clk);
    can_pop  = (model_q.size() > 0) && rdy;
    can_push = (model_q.size() < 2) && v;
    if (r) begin
      model_q.delete();
      exp_issued = 0;
      exp_stall  = 0;
    end else begin
      if (can_pop && exp_issued < 65535) exp_issued++;
      if ((model_q.size() > 0) && !rdy && exp_stall < 65535) exp_stall++;
      if (fl) begin
        model_q.delete();
      end else begin
        if (can_pop) void'(model_q.pop_front());
        if (can_push) begin
          e.inst = ins;
          e.pc   = p;
          model_q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    cycle(1, 0, 0, 32'h0, 0, 0, "rst0");
    checking = 1;
    cycle(1, 0, 0, 32'h0, 0, 1, "rst1");
    cycle(0, 0, 0, 32'h0, 0, 0, "idle");

    cycle(0, 0, 1, 32'h34011100, 6'd0, 1, "stream0");
    cycle(0, 0, 1, 32'h34020020, 6'd1, 1, "stream1");
    cycle(0, 0, 0, 32'h0, 0, 1, "stream2");
    cycle(0, 0, 0, 32'h0, 0, 1, "stream3");

    cycle(0, 0, 1, 32'hA0000002, 6'd2, 0, "bp_push2");
    cycle(0, 0, 1, 32'hA0000003, 6'd3, 0, "bp_push3");
    cycle(0, 0, 1, 32'hA0000004, 6'd4, 0, "bp_full");
    cycle(0, 0, 1, 32'hA0000004, 6'd4, 1, "bp_pop2");
    cycle(0, 0, 1, 32'hA0000004, 6'd4, 1, "bp_pop3");
    cycle(0, 0, 1, 32'hA0000005, 6'd5, 1, "bp_pop4");

    cycle(0, 0, 1, 32'hA0000006, 6'd6, 1, "pushpop");
    cycle(0, 0, 1, 32'hA0000008, 6'd8, 0, "fill");
    cycle(0, 1, 1, 32'hA0000007, 6'd7, 0, "flush");
    cycle(0, 0, 0, 32'h0, 0, 0, "post_flush");

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, $urandom, PC_W'($urandom),
            $urandom_range(0, 2) != 0, "rand");
    end

    cycle(1, 0, 0, 32'h0, 0, 0, "mid_rst");
    cycle(0, 0, 0, 32'h0, 0, 0, "after_rst");

`ifdef IF_ID_PERF_EN
    for (int i = 0; i < 70010; i++) begin
      cycle(0, 0, 1, 32'(i), PC_W'(i), 1, "sat");
    end
    cycle(0, 0, 0, 32'h0, 0, 1, "sat_hold");
    chk("sat_final", 64'(perf_issued), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter PC_W, default 6, giving the width of the fetch PC (ROM word address).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port if_valid, input, 1, meaning the fetch stage offers an instruction this cycle.
REQ-005 The block SHALL have port if_inst, input, 32, the instruction word from fetch.
REQ-006 The block SHALL have port if_pc, input, PC_W, the PC of if_inst.
REQ-007 The block SHALL have port if_ready, output, 1, meaning the buffer accepts an instruction this cycle.
REQ-008 The block SHALL have port id_valid, output, 1, meaning id_inst/id_pc hold a valid instruction for decode.
REQ-009 The block SHALL have port id_inst, output, 32, the head instruction.
REQ-010 The block SHALL have port id_pc, output, PC_W, the head PC.
REQ-011 The block SHALL have port id_ready, input, 1, meaning decode consumes the head this cycle.
REQ-012 The block SHALL have port flush, input, 1, which discards all buffered instructions (branch/exception redirect).

Function
REQ-013 The block SHALL be a 2-entry in-order FIFO of {inst, pc} pairs, with a 2-bit occupancy count and 1-bit read and write pointers.
REQ-014 The block SHALL use states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-015 Push SHALL be if_valid && if_ready; pop SHALL be id_valid && id_ready.
REQ-016 if_ready SHALL be combinational: (count != 2) && !rst.
REQ-017 id_valid SHALL equal (count != 0).
REQ-018 id_inst and id_pc SHALL be the entry at the read pointer when id_valid=1, and 32'h0 and 0 when EMPTY.
REQ-019 Latency SHALL be 1 cycle: an instruction pushed at edge N SHALL appear on id_* after edge N when the buffer was EMPTY.
REQ-020 State transitions SHALL be: push only -> count+1; pop only -> count-1; push and pop together (ONE only) -> count unchanged, both pointers advance.
REQ-021 In FULL, if_ready=0, so no push SHALL occur; a pop SHALL move the state to ONE.
REQ-022 In EMPTY, no pop SHALL occur regardless of id_ready.
REQ-023 The 1-bit pointers SHALL wrap 1 -> 0.
REQ-024 Order SHALL be strictly preserved; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-025 flush SHALL have priority over push and pop: at the edge, count and both pointers SHALL become 0, and any same-cycle push or pop SHALL be discarded.
REQ-026 After flush, the next cycle SHALL show id_valid=0 and if_ready=1.

Reset
REQ-027 While rst=1 at a rising edge, count, pointers and all entries SHALL clear to 0, taking priority over flush, push and pop.
REQ-028 After reset: id_valid=0, id_inst=32'h0, id_pc=0 and if_ready=1; during rst=1, if_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard buffered contents identically to flush.

Configuration
REQ-030 With macro IF_ID_PERF_EN defined, the block SHALL add output perf_issued[15:0], which counts pops.
REQ-031 With IF_ID_PERF_EN defined, the block SHALL add output perf_stall[15:0], which counts cycles with id_valid && !id_ready.
REQ-032 Both counters SHALL saturate at 16'hFFFF, SHALL be cleared by rst only (flush does not clear them), and SHALL be registered with 1-cycle update.
REQ-033 Without IF_ID_PERF_EN, the perf ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Reset then idle: rst=1 for 2 cycles -> id_valid=0, id_inst=0, if_ready=0 during reset and 1 after.
REQ-035 Streaming: id_ready=1, push inst 32'h34011100 at pc 0, 32'h34020020 at pc 1 on consecutive cycles -> each appears on id_* one cycle later in order, and count never exceeds 1.
REQ-036 Back-pressure: id_ready=0, push pcs 2, 3, 4 -> after two pushes if_ready=0 and pc 4 is held upstream; release id_ready -> outputs pc 2, then 3, then 4 is accepted; perf_stall (if enabled) equals the stalled cycle count.
REQ-037 Simultaneous push and pop in ONE: head pc 5, push pc 6 with id_ready=1 -> next cycle id_pc=6, count=1.
REQ-038 Flush while FULL and if_valid=1 (pc 7): flush=1 one cycle -> next cycle id_valid=0, if_ready=1, and pc 7 is not buffered.
REQ-039 Counter saturation (IF_ID_PERF_EN): 70000 pops -> perf_issued=16'hFFFF and holds.
